// File: rtl/pet_stats_engine.sv
// Virtual-pet stat engine: stats decay on a prescaled tick under random
// selection, care commands adjust them, and a mood FSM tracks the pet's health.
module pet_stats_engine #(
  parameter int          NUM_STATS  = 6,
  parameter int          STAT_W     = 4,
  parameter logic [23:0] MAX_COUNT  = 24'd10_000_000,
  parameter int          LOW_THRESH = 3,
  parameter int          DEAD_TICKS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    random,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    cmd_stat,
  input  logic                          cmd_op,
  input  logic [STAT_W-1:0]             cmd_amount,
  output logic                          cmd_err,
  output logic                          tick,
  output logic [NUM_STATS*STAT_W-1:0]   stats_flat,
  output logic [NUM_STATS-1:0]          low_mask,
  output logic [1:0]                    mood
);

  localparam logic [1:0] MOOD_HAPPY    = 2'd0;
  localparam logic [1:0] MOOD_NEEDY    = 2'd1;
  localparam logic [1:0] MOOD_CRITICAL = 2'd2;
  localparam logic [1:0] MOOD_DEAD     = 2'd3;
  localparam int HALF   = (NUM_STATS + 1) / 2;
  localparam int CRIT_W = $clog2(DEAD_TICKS + 1);
  localparam logic [STAT_W-1:0] STAT_INIT = {1'b1, {(STAT_W-1){1'b0}}};
  localparam logic [STAT_W-1:0] STAT_MAX  = '1;
  localparam logic [CRIT_W:0]   DEAD_LIM  = (CRIT_W+1)'(DEAD_TICKS);

  logic [23:0]       presc_reg;
  logic              tick_reg;
  logic              err_reg;
  logic [1:0]        mood_reg, mood_next, mood_eval;
  logic [CRIT_W-1:0] crit_reg;
  logic [CRIT_W:0]   crit_inc;
  logic              dead_now;
  logic              cmd_accept;
  logic [4:0]        zero_cnt;
  logic              any_low;
  logic [STAT_W-1:0] stat_reg  [NUM_STATS];
  logic [STAT_W-1:0] stat_next [NUM_STATS];

  assign cmd_ready  = !tick_reg && (mood_reg != MOOD_DEAD);
  assign cmd_accept = cmd_valid && cmd_ready;
  assign tick       = tick_reg;
  assign cmd_err    = err_reg;
  assign mood       = mood_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      presc_reg <= (presc_reg == MAX_COUNT - 24'd1) ? 24'd0 : presc_reg + 24'd1;
      tick_reg  <= (presc_reg == MAX_COUNT - 24'd1);
      err_reg   <= cmd_accept && (32'(cmd_stat) >= NUM_STATS);
    end
  end

  // Per-stat next value: decay has priority over a command, and DEAD freezes everything
  generate
    for (genvar gi = 0; gi < NUM_STATS; gi++) begin : g_stat
      logic [STAT_W:0]   sum;
      logic [STAT_W-1:0] cmd_val;
      logic              cmd_hit;
      assign sum     = {1'b0, stat_reg[gi]} + {1'b0, cmd_amount};
      assign cmd_hit = cmd_accept && (cmd_stat == 4'(gi));
      assign cmd_val = cmd_op ? ((stat_reg[gi] < cmd_amount) ? '0 : stat_reg[gi] - cmd_amount)
                              : (sum[STAT_W] ? STAT_MAX : sum[STAT_W-1:0]);
      assign stat_next[gi] = (mood_reg == MOOD_DEAD) ? stat_reg[gi] :
                             tick_reg ? ((random[gi % 8] && stat_reg[gi] != '0) ? stat_reg[gi] - 1'b1
                                                                                 : stat_reg[gi]) :
                             cmd_hit ? cmd_val : stat_reg[gi];
      assign stats_flat[gi*STAT_W +: STAT_W] = stat_reg[gi];
      assign low_mask[gi] = 32'(stat_reg[gi]) <= LOW_THRESH;
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_STATS; i++) begin
      stat_reg[i] <= reset ? STAT_INIT : stat_next[i];
    end
  end

  always_comb begin
    zero_cnt = '0;
    any_low  = 1'b0;
    for (int i = 0; i < NUM_STATS; i++) begin
      if (stat_reg[i] == '0) zero_cnt = zero_cnt + 5'd1;
      if (low_mask[i]) any_low = 1'b1;
    end
    mood_eval = (zero_cnt >= 5'(HALF)) ? MOOD_CRITICAL :
                any_low                ? MOOD_NEEDY    : MOOD_HAPPY;
  end

  assign crit_inc = {1'b0, crit_reg} + 1'b1;
  assign dead_now = tick_reg && (mood_reg == MOOD_CRITICAL) && (crit_inc >= DEAD_LIM);

  always_comb begin
    mood_next = mood_eval;
    if (mood_reg == MOOD_DEAD || dead_now) mood_next = MOOD_DEAD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mood_reg <= MOOD_HAPPY;
      crit_reg <= '0;
    end else begin
      mood_reg <= mood_next;
      if (mood_reg != MOOD_CRITICAL) crit_reg <= '0;
      else if (tick_reg)             crit_reg <= crit_inc[CRIT_W-1:0];
    end
  end

  // Random bits beyond the stat count are intentionally ignored
  logic unused_random;
  assign unused_random = ^random;

endmodule

// File: tb/tb_pet_stats_engine.sv
// Bench for pet_stats_engine: two configurations driven side by side and
// compared every cycle against an arithmetic reference model.
module tb_pet_stats_engine;
  localparam int MC = 4;
  localparam int DT = 8;
  localparam int LT = 3;
  localparam int NA = 6, WA = 4, NB = 3, WB = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] random;
  logic       cv [2];
  logic [3:0] cs [2];
  logic       co [2];
  logic [7:0] ca [2];

  logic rdy_a, err_a, tick_a, rdy_b, err_b, tick_b;
  logic [NA*WA-1:0] flat_a;
  logic [NB*WB-1:0] flat_b;
  logic [NA-1:0] low_a;
  logic [NB-1:0] low_b;
  logic [1:0] mood_a, mood_b;

  pet_stats_engine #(.NUM_STATS(NA), .STAT_W(WA), .MAX_COUNT(24'd4),
                     .LOW_THRESH(LT), .DEAD_TICKS(DT)) dut_a (
    .clk(clk), .reset(reset), .random(random),
    .cmd_valid(cv[0]), .cmd_ready(rdy_a), .cmd_stat(cs[0]), .cmd_op(co[0]),
    .cmd_amount(ca[0][WA-1:0]), .cmd_err(err_a), .tick(tick_a),
    .stats_flat(flat_a), .low_mask(low_a), .mood(mood_a));

  pet_stats_engine #(.NUM_STATS(NB), .STAT_W(WB), .MAX_COUNT(24'd4),
                     .LOW_THRESH(LT), .DEAD_TICKS(DT)) dut_b (
    .clk(clk), .reset(reset), .random(random),
    .cmd_valid(cv[1]), .cmd_ready(rdy_b), .cmd_stat(cs[1]), .cmd_op(co[1]),
    .cmd_amount(ca[1][WB-1:0]), .cmd_err(err_b), .tick(tick_b),
    .stats_flat(flat_b), .low_mask(low_b), .mood(mood_b));

  int tests = 0;
  int fails = 0;

  // Reference state: stat values, mood (0..3), critical tick count, visible tick/err
  int m_stat [2][16];
  int m_mood [2];
  int m_crit [2];
  int m_tick [2];
  int m_err  [2];
  int m_edges;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nstat(input int u);
    return (u == 0) ? NA : NB;
  endfunction

  function automatic int wstat(input int u);
    return (u == 0) ? WA : WB;
  endfunction

  function automatic logic [31:0] get_flat(input int u);
    return (u == 0) ? 32'(flat_a) : 32'(flat_b);
  endfunction

  function automatic logic [31:0] get_stat(input int u, input int i);
    logic [31:0] f;
    f = get_flat(u);
    return (f >> (i * wstat(u))) & ((32'd1 << wstat(u)) - 32'd1);
  endfunction

  // Mood derived directly from the rules: count zeros, look for any low stat
  function automatic int rule_mood(input int u);
    int zeros, anylow;
    zeros = 0; anylow = 0;
    for (int i = 0; i < nstat(u); i++) begin
      if (m_stat[u][i] == 0) zeros++;
      if (m_stat[u][i] <= LT) anylow = 1;
    end
    if (zeros >= (nstat(u) + 1) / 2) return 2;
    if (anylow != 0) return 1;
    return 0;
  endfunction

  task automatic model_edge();
    int n, w, mx, amt, new_mood;
    bit rdy, acc;
    if (reset) begin
      m_edges = 0;
      for (int u = 0; u < 2; u++) begin
        for (int i = 0; i < nstat(u); i++) m_stat[u][i] = 1 << (wstat(u) - 1);
        m_mood[u] = 0; m_crit[u] = 0; m_tick[u] = 0; m_err[u] = 0;
      end
      return;
    end
    m_edges++;
    for (int u = 0; u < 2; u++) begin
      n = nstat(u); w = wstat(u); mx = (1 << w) - 1;
      rdy = (m_tick[u] == 0) && (m_mood[u] != 3);
      acc = cv[u] && rdy;
      if (m_mood[u] == 3) new_mood = 3;
      else if (m_tick[u] != 0 && m_mood[u] == 2 && m_crit[u] + 1 >= DT) new_mood = 3;
      else new_mood = rule_mood(u);
      m_err[u] = (acc && int'(cs[u]) >= n) ? 1 : 0;
      if (m_mood[u] != 3) begin
        if (m_tick[u] != 0) begin
          for (int i = 0; i < n; i++)
            if (random[i % 8] && m_stat[u][i] > 0) m_stat[u][i]--;
        end else if (acc && int'(cs[u]) < n) begin
          amt = int'(ca[u]) & mx;
          if (co[u]) m_stat[u][cs[u]] = (m_stat[u][cs[u]] > amt) ? m_stat[u][cs[u]] - amt : 0;
          else       m_stat[u][cs[u]] = (m_stat[u][cs[u]] + amt > mx) ? mx : m_stat[u][cs[u]] + amt;
        end
      end
      if (m_mood[u] != 2) m_crit[u] = 0;
      else if (m_tick[u] != 0) m_crit[u]++;
      m_mood[u] = new_mood;
      m_tick[u] = (m_edges % MC == 0) ? 1 : 0;
    end
  endtask

  task automatic check_all();
    logic [31:0] ef, el;
    for (int u = 0; u < 2; u++) begin
      ef = 0; el = 0;
      for (int i = 0; i < nstat(u); i++) begin
        ef = ef | (32'(m_stat[u][i]) << (i * wstat(u)));
        if (m_stat[u][i] <= LT) el = el | (32'd1 << i);
      end
      chk($sformatf("u%0d_stats", u), get_flat(u), ef);
      chk($sformatf("u%0d_low", u), (u == 0) ? 32'(low_a) : 32'(low_b), el);
      chk($sformatf("u%0d_mood", u), (u == 0) ? 32'(mood_a) : 32'(mood_b), 32'(m_mood[u]));
      chk($sformatf("u%0d_tick", u), (u == 0) ? 32'(tick_a) : 32'(tick_b), 32'(m_tick[u]));
      chk($sformatf("u%0d_err", u), (u == 0) ? 32'(err_a) : 32'(err_b), 32'(m_err[u]));
      chk($sformatf("u%0d_ready", u), (u == 0) ? 32'(rdy_a) : 32'(rdy_b),
          32'((m_tick[u] == 0) && (m_mood[u] != 3)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_cmd(input int u, input int s, input bit op, input int amt, input int limit);
    bit rdy, accepted;
    cv[u] = 1'b1; cs[u] = 4'(s); co[u] = op; ca[u] = 8'(amt);
    accepted = 0;
    for (int k = 0; k < limit && !accepted; k++) begin
      rdy = (m_tick[u] == 0) && (m_mood[u] != 3);
      step();
      if (rdy) accepted = 1;
    end
    cv[u] = 1'b0;
    $display("[TB] u%0d cmd stat=%0d op=%0d amt=%0d accepted=%0d", u, s, op, amt, accepted);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; random = 8'h00;
    for (int u = 0; u < 2; u++) begin cv[u] = 0; cs[u] = 0; co[u] = 0; ca[u] = 0; end
    step(); step();
    chk("rst_mood", 32'(mood_a), 0);
    chk("rst_ready", 32'(rdy_a), 1);
    chk("rst_stat_a", get_stat(0, 0), 8);
    chk("rst_stat_b", get_stat(1, 2), 32);

    // Steady decay with every selection bit set
    reset = 1'b0; random = 8'hFF;
    for (int k = 0; k < 40 && get_stat(0, 0) != 3; k++) step();
    chk("decay_to3", get_stat(0, 0), 3);
    step();
    chk("needy_mood", 32'(mood_a), 1);
    chk("needy_low", 32'(low_a), 32'h3F);

    // Saturating add and subtract
    do_reset(); random = 8'h00;
    do_cmd(0, 2, 0, 6, 5);   do_cmd(1, 2, 0, 31, 5);
    chk("a_s2_14", get_stat(0, 2), 14); chk("b_s2_63", get_stat(1, 2), 63);
    do_cmd(0, 2, 0, 5, 5);   do_cmd(1, 2, 0, 5, 5);
    chk("a_sat15", get_stat(0, 2), 15); chk("b_sat63", get_stat(1, 2), 63);
    for (int r = 0; r < 2; r++) begin
      do_cmd(0, 2, 1, 15, 5); do_cmd(1, 2, 1, 63, 5);
    end
    chk("a_floor0", get_stat(0, 2), 0); chk("b_floor0", get_stat(1, 2), 0);

    // Command held across a tick collision
    do_reset(); random = 8'h00;
    for (int k = 0; k < 4; k++) step();
    chk("tick_due", 32'(tick_a), 1);
    cv[0] = 1'b1; cs[0] = 4'd0; co[0] = 1'b0; ca[0] = 8'd1;
    #1 chk("ready_on_tick", 32'(rdy_a), 0);
    step();
    chk("pending_stat0", get_stat(0, 0), 8);
    step();
    cv[0] = 1'b0;
    chk("accepted_stat0", get_stat(0, 0), 9);

    // Out-of-range index
    do_reset(); random = 8'h00;
    do_cmd(0, 9, 0, 5, 5);
    chk("err_pulse", 32'(err_a), 1);
    chk("err_nochange", get_flat(0), 32'h888888);
    step();
    chk("err_single", 32'(err_a), 0);

    // CRITICAL, then DEAD after the critical tick budget
    do_reset(); random = 8'h00;
    for (int i = 0; i < 3; i++) do_cmd(0, i, 1, 8, 5);
    for (int i = 0; i < 2; i++) do_cmd(1, i, 1, 32, 5);
    step();
    chk("crit_a", 32'(mood_a), 2); chk("crit_b", 32'(mood_b), 2);
    for (int k = 0; k < 80 && !(mood_a == 2'd3 && mood_b == 2'd3); k++) step();
    chk("dead_a", 32'(mood_a), 3); chk("dead_b", 32'(mood_b), 3);
    chk("dead_ready", 32'(rdy_a), 0);
    do_cmd(0, 0, 0, 5, 3);
    chk("dead_frozen", get_stat(0, 0), 0);
    do_reset();
    chk("revive_stat", get_stat(0, 0), 8); chk("revive_mood", 32'(mood_a), 0);
    chk("revive_b", get_stat(1, 0), 32);

    // Randomized traffic with occasional mid-run resets
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 2))
        0: random = 8'h00;
        1: random = 8'hFF;
        default: random = 8'($urandom);
      endcase
      for (int u = 0; u < 2; u++) begin
        cv[u] = 1'($urandom_range(0, 1));
        cs[u] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                            : 4'($urandom_range(0, nstat(u) - 1));
        co[u] = ($urandom_range(0, 2) == 0);
        ca[u] = 8'($urandom);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pet_stats_engine.md
PET_STATS_ENGINE -- requirements
Module: pet_stats_engine

Interface
REQ-001 SHALL have parameter NUM_STATS, default 6, number of pet stat channels (legal range 1..16).
REQ-002 SHALL have parameter STAT_W, default 4, width of each stat in bits (legal range 2..8).
REQ-003 SHALL have parameter MAX_COUNT, default 24'd10_000_000, clock cycles per decay tick.
REQ-004 SHALL have parameter LOW_THRESH, default 3, a stat at or below this value is "low".
REQ-005 SHALL have parameter DEAD_TICKS, default 8, consecutive CRITICAL ticks before DEAD.
REQ-006 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port random  input  8  free-running random byte used for decay selection.
REQ-009 SHALL have port cmd_valid  input  1  care command present.
REQ-010 SHALL have port cmd_ready  output  1  engine can accept a command this cycle.
REQ-011 SHALL have port cmd_stat  input  4  target stat index.
REQ-012 SHALL have port cmd_op  input  1  0 = add, 1 = subtract.
REQ-013 SHALL have port cmd_amount  input  STAT_W  unsigned amount.
REQ-014 SHALL have port cmd_err  output  1  one-cycle pulse when an accepted command has an out-of-range index.
REQ-015 SHALL have port tick  output  1  one-cycle decay-tick pulse.
REQ-016 SHALL have port stats_flat  output  NUM_STATS*STAT_W  all stats; stat i is at bits [i*STAT_W +: STAT_W].
REQ-017 SHALL have port low_mask  output  NUM_STATS  bit i is set when stat i <= LOW_THRESH.
REQ-018 SHALL have port mood  output  2  FSM state: 0 HAPPY, 1 NEEDY, 2 CRITICAL, 3 DEAD.

Function
REQ-019 The prescaler SHALL count 0..MAX_COUNT-1 and wrap to 0.
REQ-020 tick SHALL be registered high for exactly the one cycle after the prescaler reaches MAX_COUNT-1.
REQ-021 On a tick cycle, each stat i SHALL decrement by 1 if random[i mod 8] = 1; the decrement saturates at 0.
REQ-022 A command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both 1; the stat updates in the same edge.
REQ-023 cmd_ready SHALL be 0 on tick cycles and while mood = DEAD, and 1 otherwise; on a tick/command collision, decay wins and the command stays pending.
REQ-024 An add SHALL saturate at 2^STAT_W-1; a subtract SHALL saturate at 0; no wrap-around in either direction.
REQ-025 An accepted command with cmd_stat >= NUM_STATS SHALL change no stat and SHALL pulse cmd_err high on the following cycle.
REQ-026 low_mask SHALL be combinational from the registered stats.
REQ-027 mood SHALL be registered and evaluated every cycle from the current stats, one cycle of latency after a stat change.
REQ-028 HAPPY: no stat is low.
REQ-029 NEEDY: at least one stat is low, and fewer than ceil(NUM_STATS/2) stats are 0.
REQ-030 CRITICAL: at least ceil(NUM_STATS/2) stats are 0.
REQ-031 A critical-tick counter SHALL increment on each tick while mood = CRITICAL and clear whenever mood leaves CRITICAL.
REQ-032 On the tick where the critical-tick counter reaches DEAD_TICKS, mood SHALL go to DEAD.
REQ-033 DEAD SHALL be sticky until reset; while DEAD, stats freeze, decay stops and commands are refused.
REQ-034 Transitions among HAPPY, NEEDY and CRITICAL SHALL be free in any direction.

Reset
REQ-035 On reset, every stat SHALL load 2^(STAT_W-1) (8 at default width).
REQ-036 On reset, the prescaler and critical-tick counter SHALL clear to 0.
REQ-037 On reset, tick = 0, cmd_err = 0, mood = HAPPY, cmd_ready = 1, and low_mask reflects the reset stats.
REQ-038 Reset asserted mid-operation, including mid-handshake or in DEAD, SHALL take effect on the next edge, and any pending command is dropped.

Verification
REQ-039 Set MAX_COUNT=4 and random=8'hFF, release reset -> tick pulses every 4 cycles and all stats step 8,7,6,...; at value 3, low_mask = all ones and mood = NEEDY.
REQ-040 Stat 2 = 14, add 5 -> stat 2 = 15 (saturated); then subtract 15 twice -> stat 2 = 0 and never wraps.
REQ-041 Hold cmd_valid on the cycle a tick is due -> cmd_ready = 0 on that cycle, decay applied, command accepted on the next cycle.
REQ-042 cmd_stat = 9 with NUM_STATS = 6 -> handshake completes, all stats unchanged, cmd_err high for exactly 1 cycle.
REQ-043 Zero 3 of 6 stats and keep random = 0 -> mood = CRITICAL; after 8 ticks mood = DEAD and cmd_ready = 0; an add to stat 0 has no effect; reset -> stats = 8 and mood = HAPPY.
REQ-044 Re-run scenarios REQ-039 and REQ-040 with NUM_STATS=3, STAT_W=6 -> reset value 32, saturation at 63, CRITICAL reached at 2 zero stats.
